// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: direction counter encodings,
// counter reset/allocate values, and PC index/tag extraction helpers.
// Helpers return 32-bit values; callers cast them down to their own field widths.
package bp_pkg;

  // Strongly-not-taken: all zeros at any counter width.
  function automatic logic [31:0] cnt_snt();
    return 32'd0;
  endfunction

  // Weakly-not-taken: 0 followed by all ones.
  function automatic logic [31:0] cnt_wnt(input int cnt_w);
    return 32'((64'd1 << (cnt_w - 1)) - 64'd1);
  endfunction

  // Weakly-taken: 1 followed by all zeros.
  function automatic logic [31:0] cnt_wt(input int cnt_w);
    return 32'(64'd1 << (cnt_w - 1));
  endfunction

  // Strongly-taken: all ones.
  function automatic logic [31:0] cnt_st(input int cnt_w);
    return 32'((64'd1 << cnt_w) - 64'd1);
  endfunction

  // Counter value after reset or clear.
  function automatic logic [31:0] cnt_reset_val(input int cnt_w);
    return cnt_wnt(cnt_w);
  endfunction

  // Counter value for a freshly allocated entry.
  function automatic logic [31:0] cnt_alloc_val(input int cnt_w);
    return cnt_wt(cnt_w);
  endfunction

  // Table index: word-aligned PC bits directly above the byte offset.
  function automatic logic [31:0] pc_index(input logic [63:0] pc, input int idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

  // Tag: the PC bits directly above the index field.
  function automatic logic [31:0] pc_tag(input logic [63:0] pc, input int idx_w,
                                         input int tag_w);
    logic [63:0] mask;
    mask = (64'd1 << tag_w) - 64'd1;
    return 32'((pc >> (idx_w + 2)) & mask);
  endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// Saturating up/down direction counter (combinational next-value only).
// Holds at all-ones when incrementing and at zero when decrementing.
module bp_sat_cnt
  import bp_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt,
  input  logic         inc,
  output logic [W-1:0] cnt_nxt
);

  localparam logic [W-1:0] CNT_MAX = W'(cnt_st(W));
  localparam logic [W-1:0] CNT_MIN = W'(cnt_snt());

  // Step toward taken or not-taken, refusing to wrap at either end.
  always_comb begin
    cnt_nxt = cnt;
    if (inc) begin
      if (cnt != CNT_MAX) cnt_nxt = cnt + W'(1);
    end else begin
      if (cnt != CNT_MIN) cnt_nxt = cnt - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Lookup is combinational on the current table; updates and clears take
// effect at the rising edge, so a same-cycle lookup sees pre-update contents.
// Optional statistics counters are compiled in when BP_STATS_EN is defined.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int PC_W    = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PC_W-1:0] lkp_pc_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [PC_W-1:0] pred_next_pc_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [PC_W-1:0] upd_target_i,
  input  logic            clr_i,
  output logic            mispred_o
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_upd_o,
  output logic [31:0]     stat_mispred_o
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(cnt_reset_val(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(cnt_alloc_val(CNT_W));

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];
  logic [CNT_W-1:0] cnt_q   [ENTRIES];

  logic [IDX_W-1:0] lkp_idx;
  logic [TAG_W-1:0] lkp_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_old_taken;
  logic             upd_mispred;
  logic [CNT_W-1:0] upd_cnt;
  logic [CNT_W-1:0] upd_cnt_nxt;

  // Fetch-side prediction from the table as it stands this cycle.
  always_comb begin
    lkp_idx        = IDX_W'(pc_index(64'(lkp_pc_i), IDX_W));
    lkp_tag        = TAG_W'(pc_tag(64'(lkp_pc_i), IDX_W, TAG_W));
    pred_hit_o     = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    pred_taken_o   = pred_hit_o && cnt_q[lkp_idx][CNT_W-1];
    pred_next_pc_o = pred_taken_o ? tgt_q[lkp_idx] : lkp_pc_i + PC_W'(4);
  end

  // Re-predict the resolving branch from the old table to detect a mispredict.
  always_comb begin
    upd_idx       = IDX_W'(pc_index(64'(upd_pc_i), IDX_W));
    upd_tag       = TAG_W'(pc_tag(64'(upd_pc_i), IDX_W, TAG_W));
    upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_old_taken = upd_hit && cnt_q[upd_idx][CNT_W-1];
    upd_cnt       = cnt_q[upd_idx];
    upd_mispred   = (upd_old_taken != upd_taken_i) ||
                    (upd_old_taken && upd_taken_i && (tgt_q[upd_idx] != upd_target_i));
  end

  bp_sat_cnt #(.W(CNT_W)) u_sat_cnt (
    .cnt     (upd_cnt),
    .inc     (upd_taken_i),
    .cnt_nxt (upd_cnt_nxt)
  );

  // Table state: train on hits, allocate on taken misses; clear beats update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= CNT_RST;
      end
    end else if (clr_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_RST;
      end
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        cnt_q[upd_idx] <= upd_cnt_nxt;
        if (upd_taken_i) tgt_q[upd_idx] <= upd_target_i;
      end else if (upd_taken_i) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        tgt_q[upd_idx]   <= upd_target_i;
        cnt_q[upd_idx]   <= CNT_ALLOC;
      end
    end
  end

  // One-cycle mispredict pulse for the update accepted at this edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mispred_o <= 1'b0;
    else       mispred_o <= upd_valid_i && !clr_i && upd_mispred;
  end

`ifdef BP_STATS_EN
  // Running totals of accepted updates and mispredict pulses; clear zeroes them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_upd_o     <= '0;
      stat_mispred_o <= '0;
    end else if (clr_i) begin
      stat_upd_o     <= '0;
      stat_mispred_o <= '0;
    end else if (upd_valid_i) begin
      stat_upd_o <= stat_upd_o + 32'd1;
      if (upd_mispred) stat_mispred_o <= stat_mispred_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor (default build, BP_STATS_EN undefined).
// Vector table drives lookup/update/clear; lookup results are checked before
// the edge, mispred_o expectations go through a scoreboard queue after it.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lkpPc;
  logic        predHit;
  logic        predTaken;
  logic [31:0] predNextPc;
  logic        updValid;
  logic [31:0] updPc;
  logic        updTaken;
  logic [31:0] updTarget;
  logic        clr;
  logic        mispred;

  int vectorCount = 0;
  int missCount   = 0;

  typedef struct {
    string       name;
    logic        updValid;
    logic [31:0] updPc;
    logic        updTaken;
    logic [31:0] updTarget;
    logic        clr;
    logic [31:0] lkpPc;
    logic        expHit;
    logic        expTaken;
    logic [31:0] expNext;
    logic        expMispred;
  } vec_t;

  vec_t vecs[$];
  logic expMispredQ[$];

  branch_predictor #(
    .ENTRIES(16), .TAG_W(8), .CNT_W(2), .PC_W(32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .lkp_pc_i       (lkpPc),
    .pred_hit_o     (predHit),
    .pred_taken_o   (predTaken),
    .pred_next_pc_o (predNextPc),
    .upd_valid_i    (updValid),
    .upd_pc_i       (updPc),
    .upd_taken_i    (updTaken),
    .upd_target_i   (updTarget),
    .clr_i          (clr),
    .mispred_o      (mispred)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic addVec(input string name, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utg, input logic c,
                        input logic [31:0] lpc, input logic eh, input logic et,
                        input logic [31:0] en, input logic em);
    vec_t v;
    v.name = name; v.updValid = uv; v.updPc = upc; v.updTaken = ut;
    v.updTarget = utg; v.clr = c; v.lkpPc = lpc; v.expHit = eh;
    v.expTaken = et; v.expNext = en; v.expMispred = em;
    vecs.push_back(v);
  endtask

  task automatic checkMispred(input string name);
    logic exp;
    if (expMispredQ.size() == 0) begin
      vectorCount++;
      missCount++;
      $display("[TB] FAIL %s: scoreboard empty, got %b expected entry", name, mispred);
    end else begin
      exp = expMispredQ.pop_front();
      checkOutput({name, ".mispred"}, 32'(mispred), 32'(exp));
    end
  endtask

  // Drive one vector, check lookup before the edge, check mispred after it.
  task automatic applyStimulus(input vec_t v);
    updValid  = v.updValid;
    updPc     = v.updPc;
    updTaken  = v.updTaken;
    updTarget = v.updTarget;
    clr       = v.clr;
    lkpPc     = v.lkpPc;
    @(negedge clk);
    checkOutput({v.name, ".hit"},   32'(predHit),   32'(v.expHit));
    checkOutput({v.name, ".taken"}, 32'(predTaken), 32'(v.expTaken));
    checkOutput({v.name, ".next"},  predNextPc,     v.expNext);
    expMispredQ.push_back(v.expMispred);
    @(posedge clk);
    #1;
    checkMispred(v.name);
  endtask

  initial begin
    //     name        uv  upc            ut  utarget        clr lkp            hit tk  next           mis
    addVec("idle40",   0, 32'h0,         0, 32'h0,         0, 32'h40,       0, 0, 32'h44,       0);
    addVec("alloc40",  1, 32'h40,        1, 32'h100,       0, 32'h40,       0, 0, 32'h44,       1);
    addVec("hit40",    0, 32'h0,         0, 32'h0,         0, 32'h40,       1, 1, 32'h100,      0);
    addVec("nt1",      1, 32'h40,        0, 32'h3fc,       0, 32'h40,       1, 1, 32'h100,      1);
    addVec("nt2",      1, 32'h40,        0, 32'h3fc,       0, 32'h40,       1, 0, 32'h44,       0);
    addVec("nt3",      1, 32'h40,        0, 32'h3fc,       0, 32'h40,       1, 0, 32'h44,       0);
    addVec("t1",       1, 32'h40,        1, 32'h100,       0, 32'h40,       1, 0, 32'h44,       1);
    addVec("t2",       1, 32'h40,        1, 32'h100,       0, 32'h40,       1, 0, 32'h44,       1);
    addVec("t3",       1, 32'h40,        1, 32'h100,       0, 32'h40,       1, 1, 32'h100,      0);
    addVec("t4newtgt", 1, 32'h40,        1, 32'h180,       0, 32'h40,       1, 1, 32'h100,      1);
    addVec("ntsat",    1, 32'h40,        0, 32'h3fc,       0, 32'h40,       1, 1, 32'h180,      1);
    addVec("satchk",   0, 32'h0,         0, 32'h0,         0, 32'h40,       1, 1, 32'h180,      0);
    addVec("alias440", 1, 32'h440,       1, 32'h200,       0, 32'h440,      0, 0, 32'h444,      1);
    addVec("old40",    0, 32'h0,         0, 32'h0,         0, 32'h40,       0, 0, 32'h44,       0);
    addVec("hit440",   0, 32'h0,         0, 32'h0,         0, 32'h440,      1, 1, 32'h200,      0);
    addVec("missnt80", 1, 32'h80,        0, 32'h500,       0, 32'h80,       0, 0, 32'h84,       0);
    addVec("still80",  0, 32'h0,         0, 32'h0,         0, 32'h80,       0, 0, 32'h84,       0);
    addVec("clrupd",   1, 32'h84,        1, 32'h1000,      1, 32'h440,      1, 1, 32'h200,      0);
    addVec("aftclr",   0, 32'h0,         0, 32'h0,         0, 32'h440,      0, 0, 32'h444,      0);
    addVec("discard",  0, 32'h0,         0, 32'h0,         0, 32'h84,       0, 0, 32'h88,       0);
    addVec("alloc84",  1, 32'h84,        1, 32'h1000,      0, 32'h84,       0, 0, 32'h88,       1);
    addVec("lowbits",  0, 32'h0,         0, 32'h0,         0, 32'h87,       1, 1, 32'h1000,     0);
    addVec("pcwrap",   0, 32'h0,         0, 32'h0,         0, 32'hfffffffc, 0, 0, 32'h0,        0);

    rst = 1'b1; updValid = 1'b0; updPc = '0; updTaken = 1'b0;
    updTarget = '0; clr = 1'b0; lkpPc = 32'h40;
    #3;
    checkOutput("rst.mispred", 32'(mispred), 32'd0);
    checkOutput("rst.hit", 32'(predHit), 32'd0);
    checkOutput("rst.next", predNextPc, 32'h44);
    #9;
    rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Mispredict pulse, then asynchronous reset mid-cycle clears everything at once.
    updValid = 1'b1; updPc = 32'h84; updTaken = 1'b0; updTarget = '0; clr = 1'b0;
    lkpPc = 32'h84;
    @(posedge clk);
    #1;
    checkOutput("seqmis.mispred", 32'(mispred), 32'd1);
    updValid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("asyncrst.mispred", 32'(mispred), 32'd0);
    checkOutput("asyncrst.hit", 32'(predHit), 32'd0);
    checkOutput("asyncrst.next", predNextPc, 32'h88);

    // Updates while reset is held must not be retained.
    updValid = 1'b1; updPc = 32'hc0; updTaken = 1'b1; updTarget = 32'h777;
    @(posedge clk);
    #1;
    updValid = 1'b0;
    rst = 1'b0;
    lkpPc = 32'hc0;
    #1;
    checkOutput("rstheld.hit", 32'(predHit), 32'd0);
    checkOutput("rstheld.next", predNextPc, 32'hc4);
    @(posedge clk);
    #1;
    checkOutput("rstheld.mispred", 32'(mispred), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
